// File: rtl/uart_tx_frame.sv
// Serial UART transmitter (start, 8 data LSB first, optional parity, 1 or 2 stop) fed from a one-entry holding buffer.
// Latency: byte accepted at edge E0 drives TXD low after E1; back-to-back frames follow with zero idle clocks.
// Backpressure: TX_Ready=0 while the holding buffer is full; TX_Start in that window is ignored and its data dropped.
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-low reset
//   TX_Data   byte to send, sampled on the acceptance edge
//   TX_Start  write request, accepted when TX_Ready=1
//   TX_Ready  holding buffer empty
//   TXD       registered serial line, idles high
//   TX_Busy   frame in progress (state is not IDLE), registered with the state
//   TX_Done   one-cycle pulse on the last clock of the final stop bit

module uart_tx_frame #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] TX_Data,
    input  logic       TX_Start,
    output logic       TX_Ready,
    output logic       TXD,
    output logic       TX_Busy,
    output logic       TX_Done
);

    localparam int              CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
    localparam logic            USE_PAR   = (PARITY_EN != 0);
    localparam logic            ODD_PAR   = (PARITY_ODD != 0);
    // Index of the final stop bit: 0 for one stop bit, 1 for two.
    localparam logic            LAST_STOP = (STOP_BITS == 2);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    // Registered state
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic          stop_idx;
    logic [7:0]    shift;
    logic [7:0]    hold;
    logic          hold_full;
    logic          txd_q;
    logic          busy_q;

    // Next-state values
    logic [2:0]    state_n;
    logic [CW-1:0] cnt_n;
    logic [2:0]    bit_idx_n;
    logic          stop_idx_n;
    logic [7:0]    shift_n;
    logic [7:0]    hold_n;
    logic          hold_full_n;
    logic          txd_n;

    logic          bit_end;
    logic          last_stop;
    logic          accept;
    logic          load;
    logic          par_bit;
    logic [2:0]    bit_nx;

    assign bit_end   = (cnt == CNT_LAST);
    assign last_stop = (stop_idx == LAST_STOP);
    assign accept    = TX_Start & ~hold_full;
    assign bit_nx    = bit_idx + 3'd1;
    // Parity comes from the latched shifter so late TX_Data changes cannot leak in.
    assign par_bit   = (^shift) ^ ODD_PAR;

    always_comb begin
        state_n     = state;
        cnt_n       = bit_end ? '0 : cnt + CNT_ONE;
        bit_idx_n   = bit_idx;
        stop_idx_n  = stop_idx;
        shift_n     = shift;
        hold_n      = hold;
        hold_full_n = hold_full;
        txd_n       = txd_q;
        load        = 1'b0;

        case (state)
            S_IDLE: begin
                cnt_n = '0;
                txd_n = 1'b1;
                if (hold_full) begin
                    load    = 1'b1;
                    state_n = S_START;
                    txd_n   = 1'b0;
                end
            end

            S_START: begin
                txd_n = 1'b0;
                if (bit_end) begin
                    state_n   = S_DATA;
                    bit_idx_n = 3'd0;
                    txd_n     = shift[0];
                end
            end

            S_DATA: begin
                txd_n = shift[bit_idx];
                if (bit_end) begin
                    if (bit_idx == 3'd7) begin
                        if (USE_PAR) begin
                            state_n = S_PARITY;
                            txd_n   = par_bit;
                        end else begin
                            state_n    = S_STOP;
                            stop_idx_n = 1'b0;
                            txd_n      = 1'b1;
                        end
                    end else begin
                        bit_idx_n = bit_nx;
                        txd_n     = shift[bit_nx];
                    end
                end
            end

            S_PARITY: begin
                txd_n = par_bit;
                if (bit_end) begin
                    state_n    = S_STOP;
                    stop_idx_n = 1'b0;
                    txd_n      = 1'b1;
                end
            end

            S_STOP: begin
                txd_n = 1'b1;
                if (bit_end) begin
                    if (last_stop) begin
                        // A queued byte starts immediately: no idle clocks between frames.
                        if (hold_full) begin
                            load    = 1'b1;
                            state_n = S_START;
                            txd_n   = 1'b0;
                        end else begin
                            state_n = S_IDLE;
                        end
                    end else begin
                        stop_idx_n = 1'b1;
                    end
                end
            end

            default: begin
                state_n    = S_IDLE;
                cnt_n      = '0;
                bit_idx_n  = 3'd0;
                stop_idx_n = 1'b0;
                txd_n      = 1'b1;
            end
        endcase

        if (load) begin
            shift_n     = hold;
            hold_full_n = 1'b0;
            cnt_n       = '0;
            bit_idx_n   = 3'd0;
            stop_idx_n  = 1'b0;
        end

        // Acceptance needs hold_full=0 and unload needs hold_full=1, so the two never collide.
        if (accept) begin
            hold_n      = TX_Data;
            hold_full_n = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= 3'd0;
            stop_idx  <= 1'b0;
            shift     <= 8'd0;
            hold      <= 8'd0;
            hold_full <= 1'b0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_idx_n;
            stop_idx  <= stop_idx_n;
            shift     <= shift_n;
            hold      <= hold_n;
            hold_full <= hold_full_n;
            txd_q     <= txd_n;
            busy_q    <= (state_n != S_IDLE);
        end
    end

    assign TXD      = txd_q;
    assign TX_Busy  = busy_q;
    assign TX_Ready = ~hold_full;
    // Decoded from registered state only, so it is clean for the whole final stop clock.
    assign TX_Done  = (state == S_STOP) && bit_end && last_stop;

endmodule

// File: tb/tb_uart_tx_frame.sv
module tb_uart_tx_frame;

    localparam int N    = 16;
    localparam int FLEN = 176;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] tx_data = 8'd0;
    logic       tx_start = 1'b0;

    logic [2:0] txd_w, busy_w, rdy_w, done_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // 0: defaults (even parity, 1 stop); 1: odd parity; 2: no parity, 2 stops.
    uart_tx_frame #(.CLKS_PER_BIT(N), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
        .clk(clk), .reset(reset), .TX_Data(tx_data), .TX_Start(tx_start),
        .TX_Ready(rdy_w[0]), .TXD(txd_w[0]), .TX_Busy(busy_w[0]), .TX_Done(done_w[0]));
    uart_tx_frame #(.CLKS_PER_BIT(N), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u1 (
        .clk(clk), .reset(reset), .TX_Data(tx_data), .TX_Start(tx_start),
        .TX_Ready(rdy_w[1]), .TXD(txd_w[1]), .TX_Busy(busy_w[1]), .TX_Done(done_w[1]));
    uart_tx_frame #(.CLKS_PER_BIT(N), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u2 (
        .clk(clk), .reset(reset), .TX_Data(tx_data), .TX_Start(tx_start),
        .TX_Ready(rdy_w[2]), .TXD(txd_w[2]), .TX_Busy(busy_w[2]), .TX_Done(done_w[2]));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Frame = list of 16-clock slots: start, d0..d7, [parity], stop(s).
    function automatic logic exp_bit(input int k, input logic [7:0] b, input int pos);
        int slot;
        slot = pos / N;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        if (slot == 9 && k != 2) return (k == 1) ? ~(^b) : (^b);
        return 1'b1;
    endfunction

    bit         m_active [3];
    int         m_pos    [3];
    logic [7:0] m_cur    [3];
    bit         m_hfull  [3];
    logic [7:0] m_hbyte  [3];
    logic [7:0] exp_q[$];      // bytes instance 0 has started to send

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 3; k++) begin
                m_active[k] = 0;
                m_pos[k]    = 0;
                m_hfull[k]  = 0;
            end
            exp_q.delete();
        end else begin
            for (int k = 0; k < 3; k++) begin
                bit acc;
                acc = tx_start && !m_hfull[k];
                if (m_active[k] && m_pos[k] < FLEN - 1) begin
                    m_pos[k]++;
                end else if (m_hfull[k]) begin
                    m_active[k] = 1;
                    m_pos[k]    = 0;
                    m_cur[k]    = m_hbyte[k];
                    m_hfull[k]  = 0;
                    if (k == 0) exp_q.push_back(m_hbyte[k]);
                end else begin
                    m_active[k] = 0;
                end
                if (acc) begin
                    m_hfull[k] = 1;
                    m_hbyte[k] = tx_data;
                end
            end
        end
    end

    // ---------------- serial receiver on instance 0 ----------------
    bit         rx_on = 0;
    int         rx_t = 0;
    logic [10:0] rx_bits;
    logic [7:0] rx_byte;
    logic [7:0] rx_last = 8'h00;
    int         rx_frames = 0;

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (!reset) begin
            rx_on = 0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                logic e_txd;
                e_txd = m_active[k] ? exp_bit(k, m_cur[k], m_pos[k]) : 1'b1;
                check($sformatf("txd[%0d]", k), txd_w[k], e_txd);
                check($sformatf("busy[%0d]", k), busy_w[k], m_active[k]);
                check($sformatf("ready[%0d]", k), rdy_w[k], !m_hfull[k]);
                check($sformatf("done[%0d]", k), done_w[k], m_active[k] && m_pos[k] == FLEN - 1);
            end
            if (rx_on) rx_t++;
            else if (txd_w[0] == 1'b0) begin
                rx_on = 1;
                rx_t  = 0;
            end
            if (rx_on && (rx_t % N) == N / 2) begin
                rx_bits[rx_t / N] = txd_w[0];
                if (rx_t / N == 10) begin
                    rx_byte = rx_bits[8:1];
                    check("rx_start_bit", rx_bits[0], 1'b0);
                    check("rx_parity_error", rx_bits[9] ^ (^rx_byte), 1'b0);
                    check("rx_stop_error", rx_bits[10], 1'b1);
                    if (exp_q.size() > 0) check("rx_data", rx_byte, exp_q.pop_front());
                    else check("rx_unexpected_frame", 1, 0);
                    rx_last = rx_byte;
                    rx_frames++;
                    rx_on = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [10:0] cap_s [3];
    int          cap_done [3];
    logic        cap_first, cap_busy;
    logic [10:0] lit [3];
    int          done_cnt;
    logic        gap_txd;

    task automatic write_byte(input logic [7:0] b);
        @(negedge clk);
        tx_start = 1'b1;
        tx_data  = b;
        @(negedge clk);
        tx_start = 1'b0;
        tx_data  = ~b;      // later changes must not reach the frame
    endtask

    task automatic send_capture(input logic [7:0] b);
        write_byte(b);
        for (int k = 0; k < 3; k++) cap_done[k] = -1;
        for (int p = 0; p < FLEN; p++) begin
            @(negedge clk);
            if (p == 0) begin
                cap_first = txd_w[0];
                cap_busy  = busy_w[0];
            end
            for (int k = 0; k < 3; k++) begin
                if ((p % N) == N / 2) cap_s[k][p / N] = txd_w[k];
                if (done_w[k] && cap_done[k] < 0) cap_done[k] = p;
            end
        end
    endtask

    task automatic wait_idle(input int limit);
        bit ok, seen, prev;
        ok = 0; seen = 0; prev = 0;
        done_cnt = 0;
        gap_txd  = 1'b1;
        for (int n = 0; n < limit && !ok; n++) begin
            @(negedge clk);
            if (prev && !seen) begin
                gap_txd = txd_w[0];
                seen = 1;
            end
            if (done_w[0]) done_cnt++;
            prev = done_w[0];
            if (busy_w == 3'b000 && rdy_w == 3'b111) ok = 1;
        end
        if (!ok) check("idle_timeout", 0, 1);
    endtask

    initial begin
        int f0;
        logic [7:0] lb [4];

        // Reset state
        #12;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_txd[%0d]", k), txd_w[k], 1'b1);
            check($sformatf("rst_ready[%0d]", k), rdy_w[k], 1'b1);
            check($sformatf("rst_busy[%0d]", k), busy_w[k], 1'b0);
            check($sformatf("rst_done[%0d]", k), done_w[k], 1'b0);
        end
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;

        // Frame layout of 0xA5
        send_capture(8'hA5);
        lit[0] = {1'b1, 1'b0, 8'hA5, 1'b0};
        lit[1] = {1'b1, 1'b1, 8'hA5, 1'b0};
        lit[2] = {1'b1, 1'b1, 8'hA5, 1'b0};
        check("a5_txd_low_latency", cap_first, 1'b0);
        check("a5_busy_start", cap_busy, 1'b1);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("a5_frame[%0d]", k), cap_s[k], lit[k]);
            check($sformatf("a5_done_pos[%0d]", k), cap_done[k], 175);
        end
        wait_idle(400);

        // Parity of 0x07 (three ones)
        send_capture(8'h07);
        check("p07_even", cap_s[0][9], 1'b1);
        check("p07_odd", cap_s[1][9], 1'b0);
        check("p07_nopar_stop1", cap_s[2][9], 1'b1);
        check("p07_nopar_stop2", cap_s[2][10], 1'b1);
        wait_idle(400);

        // Loopback bytes
        lb[0] = 8'h3C; lb[1] = 8'h00; lb[2] = 8'hFF; lb[3] = 8'h80;
        for (int i = 0; i < 4; i++) begin
            f0 = rx_frames;
            write_byte(lb[i]);
            wait_idle(400);
            check("loop_byte", rx_last, lb[i]);
            check("loop_count", rx_frames - f0, 1);
        end

        // Back-to-back with a dropped third write
        f0 = rx_frames;
        write_byte(8'h01);
        for (int n = 0; n < 10 && !rdy_w[0]; n++) @(negedge clk);
        write_byte(8'h80);
        check("b2b_ready_low", rdy_w[0], 1'b0);
        write_byte(8'hEE);
        wait_idle(1000);
        check("b2b_done_pulses", done_cnt, 2);
        check("b2b_no_gap", gap_txd, 1'b0);
        check("b2b_frames", rx_frames - f0, 2);
        check("b2b_last", rx_last, 8'h80);

        // Asynchronous reset mid-frame
        write_byte(8'h96);
        repeat (60) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("arst_txd[%0d]", k), txd_w[k], 1'b1);
            check($sformatf("arst_busy[%0d]", k), busy_w[k], 1'b0);
            check($sformatf("arst_ready[%0d]", k), rdy_w[k], 1'b1);
        end
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        f0 = rx_frames;
        write_byte(8'h5A);
        wait_idle(400);
        check("post_rst_byte", rx_last, 8'h5A);
        check("post_rst_count", rx_frames - f0, 1);

        // TX_Start held high with data changing every clock
        for (int n = 0; n < 800; n++) begin
            @(negedge clk);
            tx_start = 1'b1;
            tx_data  = 8'($urandom);
        end
        @(negedge clk);
        tx_start = 1'b0;
        wait_idle(600);

        // Random sparse writes
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            tx_start = ($urandom_range(0, 3) == 0);
            tx_data  = 8'($urandom);
        end
        @(negedge clk);
        tx_start = 1'b0;
        wait_idle(600);
        repeat (4) @(negedge clk);

        check("expected_queue_drained", exp_q.size(), 0);
        check("rx_idle_at_end", rx_on, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
